// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   WORD_W / ADDR_W : default data width and memory word-address width
//   SZ_*            : request size codes (byte, half, word, illegal)
//   state_e         : controller FSM state encoding
//   req_misaligned  : error check applied to every accepted request
package mem_access_ctrl_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 16;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_CAP  = 3'd2,
      ST_RMW_RD  = 3'd3,
      ST_RMW_MRG = 3'd4,
      ST_WR      = 3'd5,
      ST_RESP    = 3'd6
   } state_e;

   // A request is rejected when its size is illegal or its address is not
   // aligned to that size; such requests never touch memory.
   function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr_lo[0];
         SZ_W:    bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering between a memory word and sub-word requests.
//   word        in  WORD_W  memory read data (mem_q)
//   addr_lo     in  2       request byte offset within the word
//   size        in  2       request size code
//   is_unsigned in  1       zero-extend loads when 1, sign-extend when 0
//   wdata       in  WORD_W  store data, value in low bits
//   load_data   out WORD_W  extracted and extended load result
//   merge_data  out WORD_W  word with store data merged into the addressed lane(s)
// Lanes are little-endian: byte k occupies bits 8k+7:8k.
module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data,
   output logic [WORD_W-1:0] merge_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane extraction for loads and lane replacement for read-modify-write stores.
   always_comb begin
      byte_s     = word[{addr_lo, 3'b000} +: 8];
      half_s     = word[{addr_lo[1], 4'b0000} +: 16];
      load_data  = {WORD_W{1'b0}};
      merge_data = word;
      case (size)
         SZ_B: begin
            load_data = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
            merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_H: begin
            load_data = {{16{half_s[15] & ~is_unsigned}}, half_s};
            merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         end
         SZ_W: begin
            load_data  = word;
            merge_data = wdata;
         end
         default: begin
            load_data  = {WORD_W{1'b0}};
            merge_data = word;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the word-wide data memory port.
// Accepts byte-addressed requests over valid/ready, performs the memory
// access (read-modify-write for byte/half stores) and returns one response.
//   clk, rst                  clock; asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid/resp_ready     response handshake (held until accepted)
//   resp_rdata, resp_err      load result / misaligned-or-illegal flag
//   mem_a, mem_w, mem_d       memory address, write enable, write data
//   mem_q                     memory read data, one cycle after mem_a
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int WORD = WORD_W,
   parameter int ADDR = ADDR_W
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [ADDR+1:0] req_addr,
   input  logic [WORD-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [WORD-1:0] resp_rdata,
   output logic            resp_err,
   output logic [ADDR-1:0] mem_a,
   output logic            mem_w,
   output logic [WORD-1:0] mem_d,
   input  logic [WORD-1:0] mem_q
);

   state_e          state_r;
   state_e          state_s;
   logic            accept_s;
   logic            bad_s;
   logic [1:0]      size_r;
   logic            uns_r;
   logic [1:0]      addr_lo_r;
   logic [WORD-1:0] wdata_r;
   logic [WORD-1:0] load_s;
   logic [WORD-1:0] merge_s;

   assign accept_s = req_valid & (state_r == ST_IDLE);
   assign bad_s    = req_misaligned(req_size, req_addr[1:0]);

   mem_lane_align u_align (
      .word        (mem_q),
      .addr_lo     (addr_lo_r),
      .size        (size_r),
      .is_unsigned (uns_r),
      .wdata       (wdata_r),
      .load_data   (load_s),
      .merge_data  (merge_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; routing is decided from the live request at accept.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!accept_s) begin
               state_s = ST_IDLE;
            end else if (bad_s) begin
               state_s = ST_RESP;
            end else if (!req_we) begin
               state_s = ST_RD;
            end else if (req_size == SZ_W) begin
               state_s = ST_WR;
            end else begin
               state_s = ST_RMW_RD;
            end
         end
         ST_RD:      state_s = ST_RD_CAP;
         ST_RD_CAP:  state_s = ST_RESP;
         ST_RMW_RD:  state_s = ST_RMW_MRG;
         ST_RMW_MRG: state_s = ST_WR;
         ST_WR:      state_s = ST_RESP;
         ST_RESP:    state_s = resp_ready ? ST_IDLE : ST_RESP;
         default:    state_s = ST_IDLE;
      endcase
   end

   // Request capture and registered outputs, all derived from the next state
   // so each output is valid for the whole cycle of the state it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= {WORD{1'b0}};
         resp_err   <= 1'b0;
         mem_a      <= {ADDR{1'b0}};
         mem_w      <= 1'b0;
         mem_d      <= {WORD{1'b0}};
         size_r     <= 2'b00;
         uns_r      <= 1'b0;
         addr_lo_r  <= 2'b00;
         wdata_r    <= {WORD{1'b0}};
      end else begin
         req_ready  <= (state_s == ST_IDLE);
         resp_valid <= (state_s == ST_RESP);
         mem_w      <= (state_s == ST_WR);
         if (accept_s) begin
            size_r     <= req_size;
            uns_r      <= req_unsigned;
            addr_lo_r  <= req_addr[1:0];
            wdata_r    <= req_wdata;
            resp_err   <= bad_s;
            resp_rdata <= {WORD{1'b0}};
            // Errored requests leave the memory address untouched.
            if (!bad_s) begin
               mem_a <= req_addr[ADDR+1:2];
            end
            // Full-word stores go straight to WR with the request data.
            if (state_s == ST_WR) begin
               mem_d <= req_wdata;
            end
         end else if (state_r == ST_RD_CAP) begin
            resp_rdata <= load_s;
         end else if (state_r == ST_RMW_MRG) begin
            mem_d <= merge_s;
         end else begin
            resp_rdata <= resp_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a 1-cycle-latency
// memory model (read-before-write) attached to the mem_* port.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [17:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [15:0] mem_a;
   logic        mem_w;
   logic [31:0] mem_d;
   logic [31:0] mem_q;

   logic [31:0] mem_bank [0:65535];
   int          wr_count = 0;
   logic [15:0] last_wa = 16'h0000;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_a        (mem_a),
      .mem_w        (mem_w),
      .mem_d        (mem_d),
      .mem_q        (mem_q)
   );

   always @(posedge clk) begin
      if (mem_w === 1'b1) begin
         mem_bank[mem_a] <= mem_d;
         wr_count        <= wr_count + 1;
         last_wa         <= mem_a;
      end
      mem_q <= mem_bank[mem_a];
   end

   // Issue one request and wait for resp_valid; lat = cycles from accept edge.
   task automatic send_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [17:0] addr, input logic [31:0] wd, output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic ack_resp();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 18'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      for (int i = 0; i < 65536; i++) mem_bank[i] = 32'h0000_0000;
      #12;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
      checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL reset_mem_w got=%b exp=0", mem_w); end
      checks++; if (mem_a !== 16'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
      checks++; if (mem_d !== 32'h0) begin errors++; $display("FAIL reset_mem_d got=%h exp=0", mem_d); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_word_store();
      int lat;
      int w0;
      w0 = wr_count;
      send_req(1'b1, 2'b10, 1'b0, 18'h008, 32'hDEADBEEF, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL sw_err got=%b exp=0", resp_err); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h exp=0", resp_rdata); end
      checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL sw_write_cycles got=%0d exp=1", wr_count - w0); end
      checks++; if (last_wa !== 16'h0002) begin errors++; $display("FAIL sw_mem_a got=%h exp=0002", last_wa); end
      checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL sw_mem_w_drop got=%b exp=0", mem_w); end
      ack_resp();
   endtask

   task automatic test_loads();
      logic [17:0] addr_t [5];
      logic [1:0]  size_t [5];
      logic        uns_t  [5];
      logic [31:0] exp_t  [5];
      int lat;
      addr_t = '{18'h008, 18'h00B, 18'h00B, 18'h00A, 18'h008};
      size_t = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
      uns_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_t  = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      for (int i = 0; i < 5; i++) begin
         send_req(1'b0, size_t[i], uns_t[i], addr_t[i], 32'h0, lat);
         checks++; if (lat != 3) begin errors++; $display("FAIL load%0d_latency got=%0d exp=3", i, lat); end
         checks++; if (resp_rdata !== exp_t[i]) begin errors++; $display("FAIL load%0d_rdata got=%h exp=%h", i, resp_rdata, exp_t[i]); end
         checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL load%0d_err got=%b exp=0", i, resp_err); end
         ack_resp();
      end
   endtask

   task automatic test_subword_store();
      int lat;
      int w0;
      w0 = wr_count;
      send_req(1'b1, 2'b00, 1'b0, 18'h009, 32'hFFFFFF55, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL sb_latency got=%0d exp=4", lat); end
      checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL sb_write_cycles got=%0d exp=1", wr_count - w0); end
      checks++; if (last_wa !== 16'h0002) begin errors++; $display("FAIL sb_mem_a got=%h exp=0002", last_wa); end
      ack_resp();
      send_req(1'b0, 2'b10, 1'b0, 18'h008, 32'h0, lat);
      checks++; if (resp_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_readback got=%h exp=DEAD55EF", resp_rdata); end
      ack_resp();
      send_req(1'b1, 2'b01, 1'b0, 18'h00E, 32'hA5A51234, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL sh_latency got=%0d exp=4", lat); end
      ack_resp();
      send_req(1'b0, 2'b10, 1'b0, 18'h00C, 32'h0, lat);
      checks++; if (resp_rdata !== 32'h12340000) begin errors++; $display("FAIL sh_readback got=%h exp=12340000", resp_rdata); end
      ack_resp();
   endtask

   task automatic test_errors();
      logic [17:0] addr_t [3];
      logic [1:0]  size_t [3];
      int lat;
      int w0;
      addr_t = '{18'h003, 18'h002, 18'h000};
      size_t = '{2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 3; i++) begin
         w0 = wr_count;
         send_req(1'b1, size_t[i], 1'b0, addr_t[i], 32'h12345678, lat);
         checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
         checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL err%0d_flag got=%b exp=1", i, resp_err); end
         checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%h exp=0", i, resp_rdata); end
         checks++; if (wr_count != w0) begin errors++; $display("FAIL err%0d_no_write got=%0d exp=%0d", i, wr_count, w0); end
         ack_resp();
      end
   endtask

   task automatic test_hold();
      int lat;
      send_req(1'b0, 2'b10, 1'b0, 18'h008, 32'h0, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD55EF || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d got valid=%b rdata=%h ready=%b exp valid=1 rdata=DEAD55EF ready=0",
                     i, resp_valid, resp_rdata, req_ready);
         end
      end
      ack_resp();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp=0", resp_valid); end
   endtask

   task automatic test_wrap();
      int lat;
      send_req(1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'h0BADF00D, lat);
      checks++; if (last_wa !== 16'hFFFF) begin errors++; $display("FAIL wrap_mem_a got=%h exp=FFFF", last_wa); end
      ack_resp();
      send_req(1'b0, 2'b10, 1'b0, 18'h3FFFC, 32'h0, lat);
      checks++; if (resp_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL wrap_readback got=%h exp=0BADF00D", resp_rdata); end
      ack_resp();
   endtask

   task automatic test_reset_mid();
      int  w0;
      int  lat;
      logic seen;
      w0 = wr_count;
      seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 18'h010; req_wdata = 32'h11111111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (mem_w !== 1'b1) begin errors++; $display("FAIL mid_in_wr got=%b exp=1", mem_w); end
      rst = 1'b0;
      #1;
      checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL mid_mem_w got=%b exp=0", mem_w); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready got=%b exp=1", req_ready); end
      checks++; if (mem_a !== 16'h0 || mem_d !== 32'h0) begin errors++; $display("FAIL mid_mem_ad got=%h/%h exp=0/0", mem_a, mem_d); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_resp got=%b exp=0", seen); end
      checks++; if (wr_count != w0) begin errors++; $display("FAIL mid_no_write got=%0d exp=%0d", wr_count, w0); end
      send_req(1'b0, 2'b10, 1'b0, 18'h010, 32'h0, lat);
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL mid_lost_data got=%h exp=0", resp_rdata); end
      ack_resp();
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_loads();
      test_subword_store();
      test_errors();
      test_hold();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
